fifo_read_packer: RTL and testbench
===================================

FIFO_READ_PACKER -- requirements
Module: fifo_read_packer

Interface
REQ-001 Parameter DATA_WIDTH, default 4, width of one word popped from the cdc_fifo read port.
REQ-002 Parameter LANES, default 2, words packed per output beat; legal range 2..8.
REQ-003 Port clock  in  1  single clock; this is the read_clock of the upstream cdc_fifo.
REQ-004 Port reset  in  1  reset; synchronous and active-high.
REQ-005 Port fifo_empty  in  1  empty flag from the fifo read side.
REQ-006 Port fifo_read_data  in  DATA_WIDTH  fifo head word; combinationally valid whenever fifo_empty=0.
REQ-007 Port fifo_read_increment  out  1  pop strobe to the fifo read side.
REQ-008 Port out_data  out  DATA_WIDTH*LANES  packed beat; first-popped word in the least-significant lane.
REQ-009 Port out_valid  out  1  out_data holds a complete beat.
REQ-010 Port out_ready  in  1  downstream accepts the beat when out_valid=1 and out_ready=1.
REQ-011 Port out_count  out  16  number of beats accepted since reset; wraps 0xFFFF->0x0000.

Function
REQ-012 The FSM SHALL have two states: FILL (out_valid=0) and PRESENT (out_valid=1).
REQ-013 pop = !reset & !fifo_empty & (state==FILL | out_ready); fifo_read_increment SHALL equal pop combinationally.
REQ-014 On a pop, fifo_read_data SHALL be captured on that same rising edge into lane lane_idx; lane_idx then increments.
REQ-015 Pop with lane_idx<LANES-1: word goes into the accumulator, and state does not change unless REQ-017 applies.
REQ-016 Pop with lane_idx=LANES-1: out_data <= {fifo_read_data, accumulator}; lane_idx <= 0; state <= PRESENT; out_valid is high on the next cycle, i.e. 1 cycle latency from the final pop.
REQ-017 PRESENT with out_ready=1: beat accepted and out_count increments. With no final pop the same cycle, state <= FILL. A same-cycle pop captures into the accumulator per REQ-014/015/016.
REQ-018 PRESENT with out_ready=0: out_data and out_valid are held stable and no pop occurs.
REQ-019 With out_ready held at 1 and the fifo never empty, the block SHALL pop every cycle and emit one beat every LANES cycles.
REQ-020 fifo_empty=1 mid-beat: the partial accumulator is held indefinitely; no beat is emitted until LANES words have been popped.
REQ-021 out_data SHALL change only on a final-lane pop; the accumulator never drives out_data directly.

Reset
REQ-022 Reset values: state=FILL, lane_idx=0, accumulator=0, out_data=0, out_valid=0, out_count=0.
REQ-023 While reset=1, fifo_read_increment SHALL be 0 regardless of fifo_empty.
REQ-024 Reset mid-beat SHALL discard the partial accumulator and any presented beat; words already popped are lost.

Configuration
REQ-025 Macro PACKER_PARITY_EN SHALL be the only compile-time option.
REQ-026 With PACKER_PARITY_EN defined: extra port out_parity (out, 1) is added. It is registered with out_data and equals the XOR of all out_data bits (even parity). Its reset value is 0.
REQ-027 Without PACKER_PARITY_EN: the out_parity port and its logic SHALL be absent, and all other behaviour is identical.

Structure
REQ-028 Package fifo_packer_pkg SHALL hold the state enum typedef (FILL, PRESENT), the OUT_COUNT_WIDTH=16 constant and the default DATA_WIDTH/LANES constants.
REQ-029 Single module with no sub-module; lane_idx width is $clog2(LANES).

Verification
REQ-030 Reset, then fifo supplies 0x3 then 0xA, out_ready=1 -> exactly 2 pops; out_data=0xA3 and out_valid=1 for one cycle; out_count=1.
REQ-031 fifo holds 1,2,3,4 with out_ready=0 -> 2 pops, 0x21 held with zero further pops; raise out_ready -> 0x21 accepted, 3 popped the same cycle, then 4 popped, next beat 0x43.
REQ-032 Word 5, fifo empty for 10 cycles, then word 6 -> out_valid stays 0 throughout the gap; then out_data=0x65.
REQ-033 Continuous fifo data with out_ready=1 for 20 cycles -> 20 pops, 10 beats, out_count=10, no bubbles.
REQ-034 One pop of 0x9, reset for 1 cycle, then 0x1, 0x2 -> 0x9 discarded; beat 0x21; out_count=1.
REQ-035 PACKER_PARITY_EN defined, beats 0x07 then 0x03 -> out_parity 1 then 0.

Source files
------------

// File: rtl/fifo_packer_pkg.sv
// Shared types and constants for the fifo read-side word packer.
package fifo_packer_pkg;
  typedef enum logic {
    FILL    = 1'b0,
    PRESENT = 1'b1
  } state_e;

  localparam int OUT_COUNT_WIDTH    = 16;
  localparam int DEFAULT_DATA_WIDTH = 4;
  localparam int DEFAULT_LANES      = 2;
endpackage

// File: rtl/fifo_read_packer.sv
// Pops words from a cdc_fifo read port and packs LANES of them into one output beat.
// Optional even-parity output enabled by defining PACKER_PARITY_EN.
module fifo_read_packer
  import fifo_packer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int LANES      = DEFAULT_LANES
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         fifo_empty,
  input  logic [DATA_WIDTH-1:0]        fifo_read_data,
  output logic                         fifo_read_increment,
  output logic [DATA_WIDTH*LANES-1:0]  out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
`ifdef PACKER_PARITY_EN
  output logic                         out_parity,
`endif
  output logic [OUT_COUNT_WIDTH-1:0]   out_count
);

  localparam int IW = $clog2(LANES);

  state_e                              state_q, state_d;
  logic [IW-1:0]                       lane_idx_q, lane_idx_d;
  logic [LANES-2:0][DATA_WIDTH-1:0]    acc_q, acc_d;
  logic [DATA_WIDTH*LANES-1:0]         out_data_q, out_data_d;
  logic [OUT_COUNT_WIDTH-1:0]          out_count_q, out_count_d;
  logic                                pop, last_lane;

  always_comb begin
    pop         = !reset && !fifo_empty && (state_q == FILL || out_ready);
    last_lane   = (lane_idx_q == IW'(LANES-1));
    state_d     = state_q;
    lane_idx_d  = lane_idx_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;

    if (pop) begin
      for (int i = 0; i < LANES-1; i++)
        if (lane_idx_q == IW'(i)) acc_d[i] = fifo_read_data;
      if (last_lane) begin
        // final word bypasses the accumulator straight into the beat
        out_data_d = {fifo_read_data, acc_q};
        lane_idx_d = '0;
      end else begin
        lane_idx_d = lane_idx_q + 1'b1;
      end
    end

    if (state_q == PRESENT && out_ready) begin
      out_count_d = out_count_q + 1'b1;
      state_d     = FILL;
    end
    if (pop && last_lane) state_d = PRESENT;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= FILL;
      lane_idx_q  <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      lane_idx_q  <= lane_idx_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
    end
  end

`ifdef PACKER_PARITY_EN
  logic parity_q;

  always_ff @(posedge clock) begin
    if (reset) parity_q <= 1'b0;
    else       parity_q <= ^out_data_d;
  end

  assign out_parity = parity_q;
`endif

  assign fifo_read_increment = pop;
  assign out_data            = out_data_q;
  assign out_valid           = (state_q == PRESENT);
  assign out_count           = out_count_q;

endmodule

// File: tb/tb_fifo_read_packer.sv
// Scoreboard bench for fifo_read_packer: queue-based fifo model, beats predicted from loaded words.
module tb_fifo_read_packer;
  localparam int DW = 4;
  localparam int LN = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic              fifo_empty;
  logic [DW-1:0]     fifo_read_data;
  logic              fifo_read_increment;
  logic [DW*LN-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_count;
`ifdef PACKER_PARITY_EN
  logic              out_parity;
`endif

  fifo_read_packer #(.DATA_WIDTH(DW), .LANES(LN)) dut (
    .clock               (clock),
    .reset               (reset),
    .fifo_empty          (fifo_empty),
    .fifo_read_data      (fifo_read_data),
    .fifo_read_increment (fifo_read_increment),
    .out_data            (out_data),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
`ifdef PACKER_PARITY_EN
    .out_parity          (out_parity),
`endif
    .out_count           (out_count)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int pops  = 0;
  int acc_cnt = 0;
  bit gap_rand = 0;
  logic [DW-1:0]    fq[$];
  logic [DW-1:0]    pend[$];
  logic [DW*LN-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every LANES loaded words form one expected beat, first word in lane 0.
  function automatic void load(input logic [DW-1:0] w);
    logic [DW*LN-1:0] b;
    fq.push_back(w);
    pend.push_back(w);
    if (pend.size() == LN) begin
      b = '0;
      for (int i = 0; i < LN; i++) b[i*DW +: DW] = pend[i];
      exp_q.push_back(b);
      pend.delete();
    end
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // fifo model: pop decided at negedge, applied after the edge, head redriven at +2
  initial begin : fifo_model
    bit did_pop;
    bit gap;
    fifo_empty     = 1'b1;
    fifo_read_data = '0;
    forever begin
      @(negedge clock);
      did_pop = fifo_read_increment;
      @(posedge clock);
      #1;
      if (did_pop && fq.size() > 0) begin
        void'(fq.pop_front());
        pops++;
      end
      #1;
      gap            = gap_rand && ($urandom_range(0, 3) == 0);
      fifo_empty     = (fq.size() == 0) || gap;
      fifo_read_data = fifo_empty ? DW'($urandom) : fq[0];
    end
  end

  // monitor / scoreboard
  initial begin : monitor
    bit prev_hold = 0;
    logic [DW*LN-1:0] prev_data = '0;
    logic [DW*LN-1:0] e;
    forever begin
      @(negedge clock);
      if (reset) begin
        chk("pop_in_reset", {31'd0, fifo_read_increment}, 32'd0);
        acc_cnt   = 0;
        prev_hold = 0;
      end else begin
        chk("pop_rule", {31'd0, fifo_read_increment},
            {31'd0, !fifo_empty && (!out_valid || out_ready)});
        chk("out_count", {16'd0, out_count}, acc_cnt);
        if (prev_hold) begin
          chk("hold_valid", {31'd0, out_valid}, 32'd1);
          chk("hold_data", {24'd0, out_data}, {24'd0, prev_data});
        end
`ifdef PACKER_PARITY_EN
        if (out_valid) chk("parity", {31'd0, out_parity}, {31'd0, ^out_data});
`endif
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) chk("unexpected_beat", 32'd1, 32'd0);
          else begin
            e = exp_q.pop_front();
            chk("beat", {24'd0, out_data}, {24'd0, e});
          end
          acc_cnt++;
        end
        prev_hold = out_valid && !out_ready;
        prev_data = out_data;
      end
    end
  end

  task automatic drain(input int bound, input bit rand_ready);
    int n = 0;
    while ((fq.size() != 0 || exp_q.size() != 0 || out_valid) && n < bound) begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    if (n >= bound) chk("drain_timeout", 32'd1, 32'd0);
    out_ready = 1'b1;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int p0;
    reset     = 1'b1;
    out_ready = 1'b0;
    repeat (3) step();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", {24'd0, out_data}, 32'd0);
    chk("rst_count", {16'd0, out_count}, 32'd0);
    reset = 1'b0;
    step();

    // two words -> one beat
    out_ready = 1'b1;
    p0 = pops;
    load(4'h3); load(4'hA);
    drain(50, 0);
    chk("t30_pops", pops - p0, 32'd2);
    chk("t30_count", {16'd0, out_count}, 32'd1);

    // backpressure holds beat, no pops while held
    out_ready = 1'b0;
    p0 = pops;
    load(4'h1); load(4'h2); load(4'h3); load(4'h4);
    repeat (8) step();
    chk("t31_pops_held", pops - p0, 32'd2);
    chk("t31_valid", {31'd0, out_valid}, 32'd1);
    chk("t31_data", {24'd0, out_data}, 32'h21);
    out_ready = 1'b1;
    drain(50, 0);
    chk("t31_pops", pops - p0, 32'd4);
    chk("t31_count", {16'd0, out_count}, 32'd3);

    // partial beat held across an empty gap
    load(4'h5);
    repeat (10) begin
      step();
      chk("t32_gap_valid", {31'd0, out_valid}, 32'd0);
    end
    load(4'h6);
    drain(50, 0);
    chk("t32_count", {16'd0, out_count}, 32'd4);

    // streaming: pop every cycle
    p0 = pops;
    for (int i = 0; i < 20; i++) load(DW'(i));
    repeat (21) step();
    chk("t33_pops_streaming", pops - p0, 32'd20);
    drain(50, 0);
    chk("t33_count", {16'd0, out_count}, 32'd14);

    // reset mid-beat discards partial word
    load(4'h9);
    repeat (3) step();
    reset = 1'b1;
    pend.delete();
    exp_q.delete();
    fq.delete();
    step();
    reset = 1'b0;
    load(4'h1); load(4'h2);
    drain(50, 0);
    chk("t34_count", {16'd0, out_count}, 32'd1);

    // parity patterns 0x07 then 0x03
    load(4'h7); load(4'h0); load(4'h3); load(4'h0);
    drain(50, 0);
    chk("t35_count", {16'd0, out_count}, 32'd3);

    // random words, random gaps, random backpressure
    gap_rand = 1'b1;
    for (int i = 0; i < 200; i++) load(DW'($urandom));
    drain(4000, 1);
    gap_rand = 1'b0;
    drain(50, 0);
    chk("rand_count", {16'd0, out_count}, 32'd103);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
